// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states,
// flag indices and instruction field positions.
package cpu_pkg;

   localparam logic [4:0] OP_ADD      = 5'd0;
   localparam logic [4:0] OP_SUB      = 5'd1;
   localparam logic [4:0] OP_OR       = 5'd2;
   localparam logic [4:0] OP_AND      = 5'd3;
   localparam logic [4:0] OP_XOR      = 5'd4;
   localparam logic [4:0] OP_SL       = 5'd5;
   localparam logic [4:0] OP_SR       = 5'd6;
   localparam logic [4:0] OP_IMM_BASE = 5'd7;
   localparam logic [4:0] OP_IMM_LAST = 5'd13;
   localparam logic [4:0] OP_GT       = 5'd14;
   localparam logic [4:0] OP_LT       = 5'd15;
   localparam logic [4:0] OP_EQ       = 5'd16;
   localparam logic [4:0] OP_BR       = 5'd17;
   localparam logic [4:0] OP_STW      = 5'd18;
   localparam logic [4:0] OP_LDW      = 5'd19;
   localparam logic [4:0] OP_BRZ      = 5'd20;
   localparam logic [4:0] OP_BRN      = 5'd21;
   localparam logic [4:0] OP_HALT     = 5'd31;

   localparam int FLAG_Z  = 0;
   localparam int FLAG_N  = 1;
   localparam int FLAG_W  = 2;

   localparam int INSTR_W = 16;
   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 11;
   localparam int RD_MSB  = 10;
   localparam int RD_LSB  = 8;
   localparam int RA_MSB  = 7;
   localparam int RA_LSB  = 5;
   localparam int RB_MSB  = 4;
   localparam int RB_LSB  = 2;
   localparam int IMM_MSB = 4;
   localparam int IMM_LSB = 0;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   // Opcodes 0..16 go through the ALU and update the flags.
   function automatic logic is_alu_op(input logic [4:0] op);
      return (op <= OP_EQ);
   endfunction

   // Immediate forms 7..13 share the function of register forms 0..6.
   function automatic logic [4:0] alu_fn(input logic [4:0] op);
      if ((op >= OP_IMM_BASE) && (op <= OP_IMM_LAST)) begin
         return op - OP_IMM_BASE;
      end else begin
         return op;
      end
   endfunction

   // Only register-form ALU ops and stores consume R[rb]; everything else takes imm.
   function automatic logic uses_rb(input logic [4:0] op);
      return (op <= OP_SR) || (op == OP_STW);
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic/logic/shift/compare with zero and negative flags.
module cpu_alu
   import cpu_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [4:0]        op_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] result_o,
   output logic              z_o,
   output logic              n_o
);

   localparam int SH_W = $clog2(DATA_W);

   logic [4:0]      fn_s;
   logic [SH_W-1:0] sh_s;

   // Result select; compares yield a single-bit 0/1 value.
   always_comb begin
      fn_s     = alu_fn(op_i);
      sh_s     = b_i[SH_W-1:0];
      result_o = '0;
      case (fn_s)
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_OR:   result_o = a_i | b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_SL:   result_o = a_i << sh_s;
         OP_SR:   result_o = a_i >> sh_s;
         OP_GT:   result_o = {{(DATA_W-1){1'b0}}, (a_i > b_i)};
         OP_LT:   result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
         OP_EQ:   result_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
         default: result_o = '0;
      endcase
      z_o = (result_o == '0);
      n_o = result_o[DATA_W-1];
   end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle 8-register core: FETCH/DECODE/EXEC/MEM/WB/HALT over a single
// req/ready memory port shared by instruction fetch and load/store.
module cpu_mc
   import cpu_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int RESET_PC = 0
) (
   input  logic              CLK,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              retire,
   output logic              halted
);

   localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic [DATA_W-1:0]    mdr_q, mdr_d;
   logic [DATA_W-1:0]    a_q, a_d;
   logic [DATA_W-1:0]    b_q, b_d;
   logic [DATA_W-1:0]    res_q, res_d;
   logic [FLAG_W-1:0]    flags_q, flags_d;
   logic                 req_q, req_d;
   logic [DATA_W-1:0]    regs_q [8];

   logic                 rf_we_s;
   logic [DATA_W-1:0]    rf_wdata_s;
   logic                 retire_s;
   logic                 xfer_s;
   logic [4:0]           op_s;
   logic [2:0]           rd_s, ra_s, rb_s;
   logic [DATA_W-1:0]    imm_s;
   logic [ADDR_W-1:0]    pc_inc_s, br_tgt_s;
   logic [DATA_W-1:0]    alu_res_s;
   logic                 alu_z_s, alu_n_s;

   assign op_s     = ir_q[OP_MSB:OP_LSB];
   assign rd_s     = ir_q[RD_MSB:RD_LSB];
   assign ra_s     = ir_q[RA_MSB:RA_LSB];
   assign rb_s     = ir_q[RB_MSB:RB_LSB];
   assign imm_s    = DATA_W'(ir_q[IMM_MSB:IMM_LSB]);
   assign pc_inc_s = pc_q + ADDR_W'(1);
   assign br_tgt_s = ADDR_W'(a_q + imm_s);
   // A ready seen while no request is outstanding must not advance the FSM.
   assign xfer_s   = req_q & mem_ready;

   cpu_alu #(.DATA_W(DATA_W)) u_alu (
      .op_i     (op_s),
      .a_i      (a_q),
      .b_i      (b_q),
      .result_o (alu_res_s),
      .z_o      (alu_z_s),
      .n_o      (alu_n_s)
   );

   // Next-state, datapath latches and retire strobe.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      mdr_d      = mdr_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      flags_d    = flags_q;
      rf_we_s    = 1'b0;
      rf_wdata_s = res_q;
      retire_s   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (xfer_s) begin
               ir_d    = mem_rdata[INSTR_W-1:0];
               state_d = ST_DECODE;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            a_d     = regs_q[ra_s];
            b_d     = uses_rb(op_s) ? regs_q[rb_s] : imm_s;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (is_alu_op(op_s)) begin
               res_d          = alu_res_s;
               flags_d[FLAG_Z] = alu_z_s;
               flags_d[FLAG_N] = alu_n_s;
               state_d        = ST_WB;
            end else begin
               case (op_s)
                  OP_BR: begin
                     pc_d     = br_tgt_s;
                     retire_s = 1'b1;
                     state_d  = ST_FETCH;
                  end
                  OP_BRZ: begin
                     pc_d     = flags_q[FLAG_Z] ? br_tgt_s : pc_inc_s;
                     retire_s = 1'b1;
                     state_d  = ST_FETCH;
                  end
                  OP_BRN: begin
                     pc_d     = flags_q[FLAG_N] ? br_tgt_s : pc_inc_s;
                     retire_s = 1'b1;
                     state_d  = ST_FETCH;
                  end
                  OP_STW, OP_LDW: state_d = ST_MEM;
                  OP_HALT:        state_d = ST_HALT;
                  default: begin
                     pc_d     = pc_inc_s;
                     retire_s = 1'b1;
                     state_d  = ST_FETCH;
                  end
               endcase
            end
         end
         ST_MEM: begin
            if (xfer_s) begin
               if (op_s == OP_LDW) begin
                  mdr_d   = mem_rdata;
                  state_d = ST_WB;
               end else begin
                  pc_d     = pc_inc_s;
                  retire_s = 1'b1;
                  state_d  = ST_FETCH;
               end
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB: begin
            rf_we_s    = 1'b1;
            rf_wdata_s = (op_s == OP_LDW) ? mdr_q : res_q;
            pc_d       = pc_inc_s;
            retire_s   = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_FETCH;
      endcase
      req_d = (state_d == ST_FETCH) || (state_d == ST_MEM);
   end

   // State, datapath and register file; reset abandons any pending transfer.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         pc_q    <= PC_RST;
         ir_q    <= '0;
         mdr_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         flags_q <= '0;
         req_q   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         mdr_q   <= mdr_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         flags_q <= flags_d;
         req_q   <= req_d;
         if (rf_we_s) begin
            regs_q[rd_s] <= rf_wdata_s;
         end
      end
   end

   assign mem_req   = req_q;
   assign mem_we    = (state_q == ST_MEM) && (op_s == OP_STW);
   assign mem_addr  = (state_q == ST_MEM) ? a_q[ADDR_W-1:0] : pc_q;
   assign mem_wdata = b_q;
   assign pc        = pc_q;
   assign retire    = retire_s & reset;
   assign halted    = (state_q == ST_HALT);

endmodule

// File: doc/cpu_mc.md
CPU_MC -- requirements
Module: cpu_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning datapath and register width (16 or 32).
REQ-002 SHALL have parameter ADDR_W, default 16, meaning memory word-address width (at most DATA_W).
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded at reset.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port mem_req, output, 1 bit: a memory transaction is requested.
REQ-007 SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port mem_addr, output, ADDR_W bits: word address.
REQ-009 SHALL have port mem_wdata, output, DATA_W bits: store data.
REQ-010 SHALL have port mem_rdata, input, DATA_W bits: read data, valid when mem_ready=1.
REQ-011 SHALL have port mem_ready, input, 1 bit: the transaction completes in this cycle.
REQ-012 SHALL have port pc, output, ADDR_W bits: the current PC.
REQ-013 SHALL have port retire, output, 1 bit: one-cycle pulse when an instruction completes.
REQ-014 SHALL have port halted, output, 1 bit: the core is in HALT.

Function
REQ-015 Instruction SHALL occupy fetched word bits [15:0], decoded as follows.
- op = IR[15:11]; rd = IR[10:8]; ra = IR[7:5]; rb = IR[4:2].
- imm = IR[4:0], zero-extended to DATA_W; imm overlaps rb.
REQ-016 Register file SHALL hold 8 x DATA_W registers, 2 read ports (ra, rb) and 1 write port (rd); no hardwired zero.
REQ-017 Opcodes SHALL be: 0-6 ADD/SUB/OR/AND/XOR/SL/SR (B = rb); 7-13 the same set with B = imm; 14 GT; 15 LT; 16 EQ; 17 BR; 18 STW; 19 LDW; 20 BRZ; 21 BRN; 31 HALT.
REQ-018 Other opcodes SHALL execute as NOP (PC+1, retire pulse).
REQ-019 Arithmetic SHALL be modulo 2^DATA_W.
REQ-020 Shifts SHALL be logical, by B[clog2(DATA_W)-1:0].
REQ-021 GT/LT SHALL compare unsigned; GT, LT and EQ write 1 or 0 to rd.
REQ-022 Flag Z (result==0) and flag N (result MSB) SHALL update only on opcodes 0-16; other opcodes leave them unchanged.
REQ-023 BR SHALL set PC = ra + imm, truncated to ADDR_W.
REQ-024 BRZ/BRN SHALL branch to the same target if Z/N is set, else PC+1.
REQ-025 LDW SHALL set rd = mem[ra].
REQ-026 STW SHALL write mem[ra] = rb.
REQ-027 FSM states SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: req=1, we=0, addr=PC; on ready, IR <= rdata, go to DECODE.
- DECODE: latch A = R[ra], B = R[rb] or imm; go to EXEC.
- EXEC: ALU ops latch result and flags, go to WB. Branches update PC, retire, go to FETCH. LDW/STW go to MEM. HALT goes to HALT. NOP does PC+1, retire, go to FETCH.
- MEM: req=1, addr = A. On ready, LDW latches MDR and goes to WB; STW does PC+1, retire, go to FETCH.
- WB: rd <= result or MDR, PC+1, retire, go to FETCH.
- HALT: no requests; halted=1; PC holds the HALT instruction's address; exit only by reset.
REQ-028 Handshake: while req=1 and ready=0, req, we, addr and wdata SHALL hold stable; ready with req=0 SHALL be ignored.
REQ-029 With ready tied to 1, latency SHALL be: ALU/compare 4 cycles, LDW 5, STW 4, branch/NOP 3.
- Each wait cycle adds 1.
REQ-030 PC increment SHALL wrap at 2^ADDR_W - 1 -> 0.
REQ-031 A WB write to a register SHALL be visible to the next instruction's DECODE.

Reset
REQ-032 On reset=0 at a clock edge the core SHALL enter FETCH with this state:
- PC = RESET_PC.
- IR, MDR, A, B, result, flags and all registers = 0.
REQ-033 During reset the outputs SHALL be: mem_req = 0, retire = 0, halted = 0.
REQ-034 Reset during a pending transaction SHALL abandon it; req is low in the next cycle and no register or PC update occurs.

Structure
REQ-035 Shared package cpu_pkg SHALL hold the opcode constants, the state enum, flag bit indices and instruction field positions.
REQ-036 Sub-module cpu_alu SHALL be parametrised by DATA_W.
- Combinational: op, A, B in; result, Z, N out.
- Instantiated once.

Verification
REQ-037 Directed scenarios:
- Reset, ready=1, memory holds ADDI r1,r0,5 at 0 -> first req at addr 0; r1=5; retire at cycle 4.
- SUB r2,r1,r1 then BRZ r0,+3 -> Z=1; next fetch addr 3; BRN not taken -> PC+1.
- STW to ra=r1(=5), rb=r2, then LDW r3 from ra=r1(=5); ready low 3 cycles each -> addr/wdata stable across waits; r3 equals stored value; LDW takes 8 cycles.
- DATA_W=32: ADD 0xFFFFFFFF+1 -> 0, Z=1, N=0; SLI by 31 of 1 -> 0x80000000, N=1.
- HALT at PC=7 -> halted=1, pc=7, no further req for 20 cycles; reset restarts at RESET_PC.
- Reset asserted mid-fetch wait -> req=0 next cycle; fetch restarts at RESET_PC; no retire pulse.
